// File: rtl/alu_packet_sequencer_if.sv
// Byte-stream and ALU-control bundle for the packet sequencer.
// master is the sequencer side; slave is the UART/ALU side.
interface alu_packet_sequencer_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        alu_start_o;
    logic        alu_done_i;
    logic [31:0] alu_result_i;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, alu_done_i, alu_result_i,
        output rx_ready_o, tx_data_o, tx_valid_o, alu_op_o, alu_a_o, alu_b_o, alu_start_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, alu_done_i, alu_result_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, alu_op_o, alu_a_o, alu_b_o, alu_start_o
    );
endinterface

// File: rtl/alu_packet_sequencer.sv
// Parses framed command packets from the RX byte stream, echoes payload or
// reduces little-endian 32-bit operands through the ALU, and returns the result.
module alu_packet_sequencer #(
    parameter logic [7:0] OPC_ECHO = 8'hEC,
    parameter logic [7:0] OPC_ADD  = 8'hAD,
    parameter logic [7:0] OPC_MUL  = 8'hAC,
    parameter logic [7:0] OPC_DIV  = 8'hD1
) (
    input  logic                          clk,
    input  logic                          rst,
    alu_packet_sequencer_if.master        bus,
    output logic                          busy_o,
    output logic                          err_o
);
    typedef enum logic [3:0] {
        S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_ECHO,
        S_COLLECT, S_EXEC, S_WAIT, S_DRAIN, S_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        have_acc_q, have_acc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [1:0]  tx_idx_q, tx_idx_d;
    logic        err_q, err_d;

    logic        rx_ready, rx_fire, tx_fire;
    logic [15:0] len_full, rem_hdr;
    logic [31:0] opnd_next;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_COLLECT, S_DRAIN: rx_ready = 1'b1;
            S_ECHO:                                              rx_ready = ~tx_valid_q;
            default:                                             rx_ready = 1'b0;
        endcase
        if (rst) rx_ready = 1'b0;
    end

    assign rx_fire   = bus.rx_valid_i & rx_ready;
    assign tx_fire   = tx_valid_q & bus.tx_ready_i;
    assign len_full  = {bus.rx_data_i, len_lo_q};
    assign rem_hdr   = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
    // Little-endian: each new byte lands in the top lane and older bytes shift down.
    assign opnd_next = {bus.rx_data_i, opnd_q[31:8]};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        byte_cnt_d = byte_cnt_q;
        have_acc_d = have_acc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_idx_d   = tx_idx_q;
        err_d      = 1'b0;

        case (state_q)
            S_HDR0: if (rx_fire) begin
                op_d    = bus.rx_data_i;
                state_d = S_HDR1;
            end
            S_HDR1: if (rx_fire) state_d = S_HDR2;
            S_HDR2: if (rx_fire) begin
                len_lo_d = bus.rx_data_i;
                state_d  = S_HDR3;
            end
            S_HDR3: if (rx_fire) begin
                rem_d      = rem_hdr;
                byte_cnt_d = 2'd0;
                have_acc_d = 1'b0;
                if (rem_hdr == 16'd0)                                    state_d = S_HDR0;
                else if (op_q == OPC_ECHO)                               state_d = S_ECHO;
                else if (op_q == OPC_ADD || op_q == OPC_MUL || op_q == OPC_DIV) state_d = S_COLLECT;
                else begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_ECHO: begin
                if (rx_fire) begin
                    tx_data_d  = bus.rx_data_i;
                    tx_valid_d = 1'b1;
                    rem_d      = rem_q - 16'd1;
                end
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    if (rem_q == 16'd0) state_d = S_HDR0;
                end
            end
            S_COLLECT: if (rx_fire) begin
                rem_d      = rem_q - 16'd1;
                opnd_d     = opnd_next;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3 && !have_acc_q) begin
                    acc_d      = opnd_next;
                    have_acc_d = 1'b1;
                    if (rem_q == 16'd1) state_d = S_SEND;
                end else if (byte_cnt_q == 2'd3) begin
                    state_d = S_EXEC;
                end else if (rem_q == 16'd1) begin
                    // Packet ended inside a partial operand; its bytes are dropped.
                    state_d = have_acc_q ? S_SEND : S_HDR0;
                end
            end
            S_EXEC: state_d = S_WAIT;
            S_WAIT: if (bus.alu_done_i) begin
                acc_d   = bus.alu_result_i;
                state_d = (rem_q == 16'd0) ? S_SEND : S_COLLECT;
            end
            S_DRAIN: if (rx_fire) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = S_HDR0;
            end
            S_SEND: if (tx_fire) begin
                if (tx_idx_q == 2'd3) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_HDR0;
                end else begin
                    tx_idx_d  = tx_idx_q + 2'd1;
                    tx_data_d = acc_q[{tx_idx_d, 3'b000} +: 8];
                end
            end
            default: state_d = S_HDR0;
        endcase

        // Any entry into SEND presents the low result byte on the very next cycle.
        if (state_d == S_SEND && state_q != S_SEND) begin
            tx_valid_d = 1'b1;
            tx_idx_d   = 2'd0;
            tx_data_d  = acc_d[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR0;
            op_q       <= 8'd0;
            len_lo_q   <= 8'd0;
            rem_q      <= 16'd0;
            acc_q      <= 32'd0;
            opnd_q     <= 32'd0;
            byte_cnt_q <= 2'd0;
            have_acc_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_idx_q   <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            byte_cnt_q <= byte_cnt_d;
            have_acc_q <= have_acc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_idx_q   <= tx_idx_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_ready_o  = rx_ready;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_valid_o  = tx_valid_q;
    assign bus.alu_op_o    = op_q;
    assign bus.alu_a_o     = acc_q;
    assign bus.alu_b_o     = opnd_q;
    assign bus.alu_start_o = (state_q == S_EXEC);
    assign busy_o          = (state_q != S_HDR0);
    assign err_o           = err_q;
endmodule

// File: tb/tb_alu_packet_sequencer.sv
// Scoreboard bench: stimulus pushes expected tx bytes and ALU starts into
// queues; a monitor pops and compares as the DUT presents them.
module tb_alu_packet_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_o, err_o;

    alu_packet_sequencer_if bus ();

    alu_packet_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miss = 0;
    int          err_seen = 0;
    int          alu_delay = 1;
    int          inject_req = 0;
    logic [7:0]  tx_exp[$];
    logic [63:0] start_exp[$];
    logic [7:0]  pkt_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural ALU: add / multiply / divide (all-ones on divide by zero).
    initial begin : alu_model
        logic [31:0] res;
        int inject_ack;
        inject_ack = 0;
        bus.alu_done_i   = 1'b0;
        bus.alu_result_i = 32'd0;
        forever begin
            @(negedge clk);
            if (inject_req != inject_ack) begin
                inject_ack       = inject_req;
                bus.alu_result_i = 32'hDEAD_BEEF;
                bus.alu_done_i   = 1'b1;
                @(negedge clk);
                bus.alu_done_i   = 1'b0;
            end else if (bus.alu_start_o && !rst) begin
                case (bus.alu_op_o)
                    8'hAD:   res = bus.alu_a_o + bus.alu_b_o;
                    8'hAC:   res = bus.alu_a_o * bus.alu_b_o;
                    default: res = (bus.alu_b_o == 32'd0) ? 32'hFFFF_FFFF : bus.alu_a_o / bus.alu_b_o;
                endcase
                repeat (alu_delay) @(negedge clk);
                bus.alu_result_i = res;
                bus.alu_done_i   = 1'b1;
                @(negedge clk);
                bus.alu_done_i   = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic       stall_prev;
        logic [7:0] data_prev;
        logic [63:0] e;
        logic [7:0]  eb;
        stall_prev = 1'b0;
        data_prev  = 8'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (stall_prev) begin
                    chk("tx_hold_valid", bus.tx_valid_o, 1);
                    chk("tx_hold_data", bus.tx_data_o, data_prev);
                end
                if (err_o) err_seen++;
                if (bus.alu_start_o) begin
                    if (start_exp.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_start: a=%0h b=%0h, expected no start", bus.alu_a_o, bus.alu_b_o);
                    end else begin
                        e = start_exp.pop_front();
                        chk("alu_start_ab", {bus.alu_a_o, bus.alu_b_o}, e);
                    end
                end
                if (bus.tx_valid_o && bus.tx_ready_i) begin
                    if (tx_exp.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_tx: got %0h, expected no byte", bus.tx_data_o);
                    end else begin
                        eb = tx_exp.pop_front();
                        chk("tx_byte", bus.tx_data_o, eb);
                    end
                end
            end
            stall_prev = !rst && bus.tx_valid_o && !bus.tx_ready_i;
            data_prev  = bus.tx_data_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        while (!bus.rx_ready_o) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                n_vec++; n_miss++;
                $display("FAIL rx_accept_timeout: byte %0h not accepted, expected acceptance", b);
                break;
            end
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
    endtask

    task automatic exp_tx4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) tx_exp.push_back(v[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int  n = 0;
        logic stuck;
        while ((busy_o || tx_exp.size() != 0 || start_exp.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        stuck = busy_o || tx_exp.size() != 0 || start_exp.size() != 0;
        chk({name, "_idle"}, stuck, 0);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_rx_ready"}, bus.rx_ready_o, 0);
        chk({name, "_tx_valid"}, bus.tx_valid_o, 0);
        chk({name, "_tx_data"},  bus.tx_data_o, 0);
        chk({name, "_start"},    bus.alu_start_o, 0);
        chk({name, "_alu_a"},    bus.alu_a_o, 0);
        chk({name, "_alu_b"},    bus.alu_b_o, 0);
        chk({name, "_alu_op"},   bus.alu_op_o, 0);
        chk({name, "_busy"},     busy_o, 0);
        chk({name, "_err"},      err_o, 0);
    endtask

    initial begin : stim
        int err_base;
        int n;
        bus.rx_data_i  = 8'd0;
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("hdr0_rx_ready", bus.rx_ready_o, 1);

        // Echo with tx backpressure; a pending rx byte must not be taken while stalled.
        tx_exp.push_back(8'h41); tx_exp.push_back(8'h42); tx_exp.push_back(8'h43);
        pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00};
        send_pkt();
        bus.tx_ready_i = 1'b0;
        send_byte(8'h41);
        bus.rx_data_i  = 8'h42;
        bus.rx_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("echo_stall_rx_ready", bus.rx_ready_o, 0);
            chk("echo_stall_tx_valid", bus.tx_valid_o, 1);
        end
        bus.tx_ready_i = 1'b1;
        send_byte(8'h42);
        send_byte(8'h43);
        wait_idle("echo");

        // Add, with the ALU held off for 20 cycles.
        start_exp.push_back({32'd5, 32'd7});
        exp_tx4(32'd12);
        alu_delay = 20;
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("wait_rx_ready", bus.rx_ready_o, 0);
        end
        wait_idle("add");
        alu_delay = 1;

        // Multiply chain with SEND stalled.
        start_exp.push_back({32'd2, 32'd3});
        start_exp.push_back({32'd6, 32'd4});
        exp_tx4(32'd24);
        bus.tx_ready_i = 1'b0;
        pkt_q = '{8'hAC, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                  8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_pkt();
        n = 0;
        while (!bus.tx_valid_o && n < 100) begin @(negedge clk); n++; end
        chk("send_tx_valid_rise", bus.tx_valid_o, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("send_stall_valid", bus.tx_valid_o, 1);
            chk("send_stall_rx_ready", bus.rx_ready_o, 0);
        end
        bus.tx_ready_i = 1'b1;
        wait_idle("mul");

        // Same chain with two trailing bytes of an incomplete operand.
        start_exp.push_back({32'd2, 32'd3});
        start_exp.push_back({32'd6, 32'd4});
        exp_tx4(32'd24);
        pkt_q = '{8'hAC, 8'h00, 8'h12, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                  8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        send_pkt();
        wait_idle("mul_trail");

        // Unknown opcode drains silently, then echo still works.
        err_base = err_seen;
        pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt();
        wait_idle("unknown");
        chk("err_pulses", err_seen - err_base, 1);
        tx_exp.push_back(8'h5A);
        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt();
        wait_idle("echo_after_err");

        // Single operand returns itself with no ALU start.
        exp_tx4(32'h1234_5678);
        pkt_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_pkt();
        wait_idle("single");

        // Divide.
        start_exp.push_back({32'd100, 32'd7});
        exp_tx4(32'd14);
        pkt_q = '{8'hD1, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("div");

        // Reset mid-operand, stale done ignored, then a clean add.
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
        send_pkt();
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        inject_req++;
        repeat (3) @(negedge clk);
        chk("stale_done_busy", busy_o, 0);
        chk("stale_done_tx_valid", bus.tx_valid_o, 0);
        start_exp.push_back({32'd9, 32'd1});
        exp_tx4(32'd10);
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle("add_after_rst");

        // len=2 header: no response, back in HDR0.
        pkt_q = '{8'hEC, 8'h00, 8'h02, 8'h00};
        send_pkt();
        chk("len2_busy", busy_o, 0);
        chk("len2_rx_ready", bus.rx_ready_o, 1);
        tx_exp.push_back(8'h77);
        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        send_pkt();
        wait_idle("echo_after_len2");

        repeat (5) @(negedge clk);
        chk("tx_queue_empty", tx_exp.size(), 0);
        chk("start_queue_empty", start_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
